// File: rtl/memory_game_sm_pkg.sv
// -----------------------------------------------------------------------------
// memgame_pkg
// Shared definitions for the memory game: the FSM state enum, the LFSR
// feedback tap mask, the default LFSR seed, the starting number of lives,
// and two helper functions (one-hot state decode and LFSR feedback bit).
// No ports. Imported by memgame_lfsr and memory_game_sm.
// -----------------------------------------------------------------------------
package memgame_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SHOW = 3'd1,
      PLAY = 3'd2,
      GOOD = 3'd3,
      FAIL = 3'd4
   } state_e;

   // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (maximal length),
   // i.e. bits 15, 13, 12 and 10 of the shift register.
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
   localparam logic [1:0]  LIVES_INIT        = 2'd3;

   // One-hot flag vector ordered {fail-over, good, play, show, idle}.
   function automatic logic [4:0] state_flags(input state_e s);
      logic [4:0] f;
      case (s)
         IDLE:    f = 5'b00001;
         SHOW:    f = 5'b00010;
         PLAY:    f = 5'b00100;
         GOOD:    f = 5'b01000;
         FAIL:    f = 5'b10000;
         default: f = 5'b00001;
      endcase
      return f;
   endfunction

   // XOR of the tapped bits; shifted into bit 0 each cycle.
   function automatic logic lfsr_feedback(input logic [15:0] v);
      return ^(v & LFSR_TAPS);
   endfunction

endpackage

// File: rtl/memory_game_sm_if.sv
// -----------------------------------------------------------------------------
// memory_game_sm_if
// Groups the memory game's button inputs and display outputs.
//   btnU/btnD/btnL/btnR/btnC : debounced single-cycle button pulses
//   X, Y                     : cursor row / column
//   A0..A3                   : target pattern rows (Ak[j] = row k, column j)
//   B0..B3                   : guessed-cell rows, same indexing as A
//   Qi, Ql, Qp, Qg, Qfo      : one-hot state flags idle/show/play/good/fail
//   lives                    : remaining lives (0 when the feature is off)
// Modports: master drives buttons and observes outputs; slave is the game.
// -----------------------------------------------------------------------------
interface memory_game_sm_if;
   logic       btnU, btnD, btnL, btnR, btnC;
   logic [1:0] X, Y;
   logic [3:0] A0, A1, A2, A3;
   logic [3:0] B0, B1, B2, B3;
   logic       Qi, Ql, Qp, Qg, Qfo;
   logic [1:0] lives;

   modport master (
      output btnU, btnD, btnL, btnR, btnC,
      input  X, Y, A0, A1, A2, A3, B0, B1, B2, B3, Qi, Ql, Qp, Qg, Qfo, lives
   );

   modport slave (
      input  btnU, btnD, btnL, btnR, btnC,
      output X, Y, A0, A1, A2, A3, B0, B1, B2, B3, Qi, Ql, Qp, Qg, Qfo, lives
   );
endinterface

// File: rtl/memory_game_sm_lfsr.sv
// -----------------------------------------------------------------------------
// memgame_lfsr
// Free-running 16-bit maximal-length Fibonacci LFSR that advances every
// cycle. A non-zero seed keeps it out of the all-zero lock-up state.
//   clk  : clock
//   rst  : synchronous active-high reset, loads seed
//   seed : reset value (must be non-zero)
//   q    : current register value
// -----------------------------------------------------------------------------
module memgame_lfsr
   import memgame_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] seed,
   output logic [15:0] q
);
   logic [15:0] q_q;
   logic [15:0] q_d;

   // Shift left, feedback into bit 0.
   always_comb begin
      q_d = {q_q[14:0], lfsr_feedback(q_q)};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= seed;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;
endmodule

// File: rtl/memory_game_sm.sv
// -----------------------------------------------------------------------------
// memory_game_sm
// 4x4 memory game controller. From idle, btnC latches a random pattern and
// shows it for SHOW_CYCLES clocks; the player then moves a cursor and marks
// cells. Marking every pattern cell wins, marking a non-pattern cell loses
// (or costs a life when MEMGAME_LIVES_EN is defined).
//   clk, rst : clock, synchronous active-high reset
//   bus      : memory_game_sm_if.slave (buttons in; cursor, pattern, guesses,
//              one-hot state flags and lives out; all outputs registered)
// Parameters: SHOW_CYCLES (display duration), LFSR_SEED (non-zero).
// Optional feature macro: MEMGAME_LIVES_EN (three lives instead of one).
// -----------------------------------------------------------------------------
module memory_game_sm
   import memgame_pkg::*;
#(
   parameter int unsigned SHOW_CYCLES = 32'd100000000,
   parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
   input logic             clk,
   input logic             rst,
   memory_game_sm_if.slave bus
);
   state_e      state_q, state_d;
   logic [4:0]  flags_q;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [1:0]  x_q, x_d;
   logic [1:0]  y_q, y_d;
   logic [31:0] timer_q, timer_d;
   logic [15:0] lfsr_s;
   logic [3:0]  cell_s;
   logic [15:0] b_set_s;
`ifdef MEMGAME_LIVES_EN
   logic [1:0]  lives_q, lives_d;
`endif

   memgame_lfsr u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .seed (LFSR_SEED),
      .q    (lfsr_s)
   );

   // Cell (row X, column Y) lives at bit 4*X+Y of the flattened {A3..A0}.
   assign cell_s  = {x_q, y_q};
   assign b_set_s = b_q | (16'd1 << cell_s);

   // Next-state and datapath logic for the game FSM.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      x_d     = x_q;
      y_d     = y_q;
      timer_d = timer_q;
`ifdef MEMGAME_LIVES_EN
      lives_d = lives_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.btnC) begin
               // B mirrors the new pattern for the whole display window.
               a_d     = lfsr_s;
               b_d     = lfsr_s;
               x_d     = 2'd0;
               y_d     = 2'd0;
               timer_d = 32'(SHOW_CYCLES - 32'd1);
`ifdef MEMGAME_LIVES_EN
               lives_d = LIVES_INIT;
`endif
               state_d = SHOW;
            end else begin
               state_d = IDLE;
            end
         end
         SHOW: begin
            if (timer_q == 32'd0) begin
               b_d     = 16'd0;
               state_d = PLAY;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         PLAY: begin
            // One action per cycle: C > U > D > L > R.
            if (bus.btnC) begin
               if (b_q[cell_s]) begin
                  b_d = b_q;
               end else begin
                  b_d = b_set_s;
                  if (a_q[cell_s]) begin
                     if ((a_q & ~b_set_s) == 16'd0) begin
                        state_d = GOOD;
                     end else begin
                        state_d = PLAY;
                     end
                  end else begin
`ifdef MEMGAME_LIVES_EN
                     if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                        state_d = PLAY;
                     end else begin
                        lives_d = 2'd0;
                        state_d = FAIL;
                     end
`else
                     state_d = FAIL;
`endif
                  end
               end
            end else if (bus.btnU) begin
               x_d = x_q - 2'd1;
            end else if (bus.btnD) begin
               x_d = x_q + 2'd1;
            end else if (bus.btnL) begin
               y_d = y_q - 2'd1;
            end else if (bus.btnR) begin
               y_d = y_q + 2'd1;
            end else begin
               x_d = x_q;
            end
         end
         GOOD, FAIL: begin
            if (bus.btnC) begin
               b_d     = 16'd0;
               state_d = IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM and output registers; flags are registered from the next state so
   // they change on the same edge as the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         flags_q <= state_flags(IDLE);
         a_q     <= 16'd0;
         b_q     <= 16'd0;
         x_q     <= 2'd0;
         y_q     <= 2'd0;
         timer_q <= 32'd0;
      end else begin
         state_q <= state_d;
         flags_q <= state_flags(state_d);
         a_q     <= a_d;
         b_q     <= b_d;
         x_q     <= x_d;
         y_q     <= y_d;
         timer_q <= timer_d;
      end
   end

`ifdef MEMGAME_LIVES_EN
   // Lives counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         lives_q <= LIVES_INIT;
      end else begin
         lives_q <= lives_d;
      end
   end
   assign bus.lives = lives_q;
`else
   assign bus.lives = 2'd0;
`endif

   assign bus.X   = x_q;
   assign bus.Y   = y_q;
   assign bus.A0  = a_q[3:0];
   assign bus.A1  = a_q[7:4];
   assign bus.A2  = a_q[11:8];
   assign bus.A3  = a_q[15:12];
   assign bus.B0  = b_q[3:0];
   assign bus.B1  = b_q[7:4];
   assign bus.B2  = b_q[11:8];
   assign bus.B3  = b_q[15:12];
   assign bus.Qi  = flags_q[0];
   assign bus.Ql  = flags_q[1];
   assign bus.Qp  = flags_q[2];
   assign bus.Qg  = flags_q[3];
   assign bus.Qfo = flags_q[4];
endmodule
